// File: rtl/fp32_pkg.sv
// fp32_pkg: shared IEEE-754 single-precision definitions for the FP datapath.
// Holds field geometry, canonical constants, the sequential FSM state
// encoding and the unpacked operand record used by fp32_unpack/fsub_seq.
package fp32_pkg;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MANT_W   = 23;
    localparam int unsigned BIAS     = 127;

    localparam logic [31:0] FP_ZERO   = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;
    localparam logic [31:0] FP_MAXFIN = 32'h7F7F_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        PACK
    } state_t;

    // mant carries the hidden bit in [MANT_W]
    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W:0]   mant;
    } fp_unpacked_t;

endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack: combinational IEEE-754 single unpacker.
// Ports:
//   word   - packed 32-bit operand
//   fp     - {sign, exp, mant[23:0]} with hidden bit; exp==0 flushes mant to 0
//   is_inf - (FSUB_SPECIAL_EN only) exp all ones, fraction zero
//   is_nan - (FSUB_SPECIAL_EN only) exp all ones, fraction non-zero
// Macro: FSUB_SPECIAL_EN adds the special-value flag outputs.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]  word,
    output fp_unpacked_t fp
`ifdef FSUB_SPECIAL_EN
    ,
    output logic         is_inf,
    output logic         is_nan
`endif
);

    logic [EXP_W-1:0]  e;
    logic [MANT_W-1:0] f;

    assign e = word[30:23];
    assign f = word[22:0];

    always_comb begin
        fp.sign = word[SIGN_BIT];
        fp.exp  = e;
        fp.mant = (e == '0) ? '0 : {1'b1, f};
    end

`ifdef FSUB_SPECIAL_EN
    assign is_inf = (e == '1) && (f == '0);
    assign is_nan = (e == '1) && (f != '0);
`endif

endmodule

// File: rtl/fsub_seq.sv
// fsub_seq: multi-cycle IEEE-754 single subtractor, y = a - b, truncating.
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   start       - request, sampled only while busy=0
//   a, b        - minuend / subtrahend
//   busy        - high from the accepting edge until done
//   done        - one-cycle pulse, y valid from this cycle
//   y           - result, held until the next operation packs
// Parameter MAX_NORM bounds the left-normalisation shifts per operation.
// Macro: FSUB_SPECIAL_EN enables NaN/Inf decoding and overflow-to-Inf.
module fsub_seq
    import fp32_pkg::*;
#(
    parameter int unsigned MAX_NORM = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] y
);

    localparam int unsigned CNT_W = $clog2(MAX_NORM + 2);

    state_t            state, state_nxt;
    logic [31:0]       a_q, b_q;
    logic              sign_q, sub_q, pend_q;
    logic [7:0]        exp_q;
    logic [23:0]       sum_q, ym_q;
    logic [CNT_W-1:0]  cnt_q;

    fp_unpacked_t      ua, ub, ux, uy;
    logic [7:0]        ediff;
    logic [23:0]       y_shift;
    logic [24:0]       add_sum;
    logic [23:0]       norm_sum;
    logic [7:0]        norm_exp;
    logic              norm_ok, norm_last;

    logic              nxt_sign, nxt_sub, to_pack;
    logic [7:0]        nxt_exp;
    logic [23:0]       nxt_sum, nxt_ym;
    logic [CNT_W-1:0]  nxt_cnt;

`ifdef FSUB_SPECIAL_EN
    logic a_inf, a_nan, b_inf, b_nan;
    fp32_unpack u_unpack_a (.word(a_q), .fp(ua), .is_inf(a_inf), .is_nan(a_nan));
    fp32_unpack u_unpack_b (.word(b_q), .fp(ub), .is_inf(b_inf), .is_nan(b_nan));
`else
    fp32_unpack u_unpack_a (.word(a_q), .fp(ua));
    fp32_unpack u_unpack_b (.word(b_q), .fp(ub));
`endif

    // Magnitude ordering and alignment of the smaller operand
    always_comb begin
        if ({ua.exp, ua.mant} >= {ub.exp, ub.mant}) begin
            ux = ua;
            uy = ub;
        end else begin
            ux = ub;
            uy = ua;
        end
        ediff   = ux.exp - uy.exp;
        y_shift = (ediff >= 8'd25) ? '0 : (uy.mant >> ediff);
    end

    // sum_q holds X.mant between ALIGN and ADD, then the working sum
    assign add_sum   = sub_q ? ({1'b0, sum_q} - {1'b0, ym_q})
                             : ({1'b0, sum_q} + {1'b0, ym_q});
    assign norm_sum  = {sum_q[22:0], 1'b0};
    assign norm_exp  = exp_q - 8'd1;
    assign norm_ok   = (exp_q > 8'd1) && (cnt_q < CNT_W'(MAX_NORM));
    assign norm_last = (cnt_q == CNT_W'(MAX_NORM - 1));

    // Datapath step for the current state; to_pack selects the early exit
    always_comb begin
        nxt_sign = sign_q;
        nxt_sub  = sub_q;
        nxt_exp  = exp_q;
        nxt_sum  = sum_q;
        nxt_ym   = ym_q;
        nxt_cnt  = cnt_q;
        to_pack  = 1'b0;
        case (state)
            ALIGN: begin
                nxt_sign = ux.sign;
                nxt_exp  = ux.exp;
                nxt_sum  = ux.mant;
                nxt_ym   = y_shift;
                nxt_sub  = ux.sign ^ uy.sign;
`ifdef FSUB_SPECIAL_EN
                if (a_nan || b_nan || (a_inf && b_inf && (ua.sign != ub.sign))) begin
                    to_pack  = 1'b1;
                    nxt_sign = FP_QNAN[SIGN_BIT];
                    nxt_exp  = FP_QNAN[30:23];
                    nxt_sum  = {1'b0, FP_QNAN[22:0]};
                end else if (a_inf || b_inf) begin
                    to_pack  = 1'b1;
                    nxt_sign = a_inf ? ua.sign : ub.sign;
                    nxt_exp  = '1;
                    nxt_sum  = '0;
                end
`endif
            end
            ADD: begin
                if (add_sum[24]) begin
                    to_pack = 1'b1;
                    if (exp_q >= 8'd254) begin
`ifdef FSUB_SPECIAL_EN
                        nxt_exp = '1;
                        nxt_sum = '0;
`else
                        nxt_exp = FP_MAXFIN[30:23];
                        nxt_sum = {1'b1, FP_MAXFIN[22:0]};
`endif
                    end else begin
                        nxt_exp = exp_q + 8'd1;
                        nxt_sum = add_sum[24:1];
                    end
                end else if (add_sum == '0) begin
                    // exact cancellation is always +0
                    to_pack  = 1'b1;
                    nxt_sign = 1'b0;
                    nxt_exp  = '0;
                    nxt_sum  = '0;
                end else if (add_sum[23]) begin
                    to_pack = 1'b1;
                    nxt_sum = add_sum[23:0];
                end else if (exp_q <= 8'd1) begin
                    to_pack = 1'b1;
                    nxt_exp = '0;
                    nxt_sum = '0;
                end else begin
                    nxt_sum = add_sum[23:0];
                end
            end
            NORM: begin
                if (!norm_ok) begin
                    to_pack = 1'b1;
                end else begin
                    nxt_sum = norm_sum;
                    nxt_exp = norm_exp;
                    nxt_cnt = cnt_q + CNT_W'(1);
                    // exit decision looks at the post-shift value so the
                    // normalising shift and the hand-off share one cycle
                    if (norm_sum[23] || norm_last) begin
                        to_pack = 1'b1;
                    end else if (norm_exp == 8'd1) begin
                        to_pack = 1'b1;
                        nxt_exp = '0;
                        nxt_sum = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ALIGN;
            ALIGN:   state_nxt = to_pack ? PACK : ADD;
            ADD:     state_nxt = to_pack ? PACK : NORM;
            NORM:    state_nxt = to_pack ? PACK : NORM;
            PACK:    if (pend_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sign_q <= 1'b0;
            sub_q  <= 1'b0;
            pend_q <= 1'b0;
            exp_q  <= '0;
            sum_q  <= '0;
            ym_q   <= '0;
            cnt_q  <= '0;
            done   <= 1'b0;
            y      <= FP_ZERO;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= {~b[SIGN_BIT], b[SIGN_BIT-1:0]};
                        cnt_q  <= '0;
                        pend_q <= 1'b0;
                    end
                end
                ALIGN, ADD, NORM: begin
                    sign_q <= nxt_sign;
                    sub_q  <= nxt_sub;
                    exp_q  <= nxt_exp;
                    sum_q  <= nxt_sum;
                    ym_q   <= nxt_ym;
                    cnt_q  <= nxt_cnt;
                end
                PACK: begin
                    // first PACK cycle writes y, second raises done
                    if (!pend_q) begin
                        y      <= {sign_q, exp_q, sum_q[22:0]};
                        pend_q <= 1'b1;
                    end else begin
                        done   <= 1'b1;
                        pend_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fsub_seq.sv
module tb_fsub_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] y;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] y;
        int unsigned at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    fsub_seq #(.MAX_NORM(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: y=%h at cycle %0d, no pending op", y, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("y", y, mon_e.y);
                chk("done_cycle", cyc, mon_e.at);
                chk("busy_at_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b expected 0 within 300 cycles", busy);
        end
    endtask

    // Issue one op at a negedge; edge E is the next posedge
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv,
                          input logic [31:0] ey, input int unsigned lat, input string nm);
        int unsigned e_edge;
        wait_idle();
        a      = ta;
        b      = tbv;
        start  = 1'b1;
        e_edge = cyc + 1;
        sb.push_back('{ey, e_edge + lat});
        @(negedge clk);
        start = 1'b0;
        chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_y", y, 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h40C0_0000, 32'h4090_0000, 32'h3FC0_0000, 6, "sub6_45");
        run_op(32'h411A_B852, 32'h410A_B852, 32'h3F80_0000, 7, "sub967_867");
        run_op(32'h410A_B852, 32'h410A_B852, 32'h0000_0000, 4, "equal");
        run_op(32'h3FC0_0000, 32'hC090_0000, 32'h40C0_0000, 4, "sub_neg");

        run_op(32'h4D8A_4728, 32'h3FBC_CCCD, 32'h4D8A_4728, 4, "bigshift");
        a = 32'h3F80_0000;
        b = 32'h3F80_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        run_op(32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 5, "neg_result");
        run_op(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 4, "carry");
        run_op(32'h3F80_0000, 32'hB400_0000, 32'h3F80_0001, 4, "shift23");
        run_op(32'h0100_0001, 32'h0100_0000, 32'h0000_0000, 5, "flush_min");
        run_op(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4, "zero_zero");
        run_op(32'h0040_0000, 32'h3F80_0000, 32'hBF80_0000, 4, "denorm");
`ifdef FSUB_SPECIAL_EN
        run_op(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 3, "inf_inf");
        run_op(32'h7F80_0001, 32'h0000_0000, 32'h7FC0_0000, 3, "nan_in");
        run_op(32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 3, "minus_inf");
        run_op(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 3, "plus_inf");
        run_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4, "ovf_inf");
`else
        run_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F7F_FFFF, 4, "saturate");
`endif

        // Reset mid-operation discards the op
        run_op(32'h40C0_0000, 32'h4090_0000, 32'h3FC0_0000, 6, "pre_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midreset_busy", {31'b0, busy}, 32'd0);
        chk("midreset_done", {31'b0, done}, 32'd0);
        chk("midreset_y", y, 32'h0000_0000);
        @(negedge clk);
        @(negedge clk);
        chk("inreset_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;

        run_op(32'h40C0_0000, 32'h4090_0000, 32'h3FC0_0000, 6, "post_reset");

        begin : drain
            int unsigned n = 0;
            while (sb.size() != 0 && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (sb.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout: %0d results never produced", sb.size());
            end
        end
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
